// File: rtl/xarb_rr_pkt_if.sv
// Packet arbiter bus: N request channels in, one shared channel out.
// The slave modport is the arbiter; the master modport drives it.
interface xarb_rr_pkt_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic            out_last;
  logic [DW-1:0]   out_data;
  logic            out_ready;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data
  );
endinterface

// File: rtl/xarb_rr_pkt.sv
// Round-robin packet arbiter: grant is locked per packet,
// and one IDLE cycle separates consecutive packets.
module xarb_rr_pkt #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  xarb_rr_pkt_if.slave bus,
  output logic [N-1:0] grant,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [N-1:0] PTR_RST = N'(1) << (N-1);

  state_t       state, state_n;
  logic [N-1:0] ptr, ptr_n;
  logic [N-1:0] grant_n;
  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] req;
  logic [N-1:0] win;

  // Prefer requesters above the last winner, else wrap to bit 0.
  always_comb begin
    hi_mask = ~((ptr << 1) - N'(1));
    req_hi  = bus.in_valid & hi_mask;
    req     = (|req_hi) ? req_hi : bus.in_valid;
    win     = req & (~req + N'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= PTR_RST;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n       = state;
    grant_n       = grant;
    ptr_n         = ptr;
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.in_valid) begin
          grant_n = win;
          state_n = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (grant[i]) begin
            bus.out_valid   = bus.in_valid[i];
            bus.out_last    = bus.in_last[i];
            bus.out_data    = bus.in_data[i*DW +: DW];
            bus.in_ready[i] = bus.out_ready;
          end
        end
        if (bus.out_valid && bus.out_ready && bus.out_last) begin
          ptr_n   = grant;
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xarb_rr_pkt.sv
// Directed bench for xarb_rr_pkt with N=4, DW=32.
// Transferred beats are logged on the falling edge.
module tb_xarb_rr_pkt;
  localparam int N  = 4;
  localparam int DW = 32;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] grant;
  logic         busy;
  int           checks;
  int           failures;
  logic [DW-1:0] seen[$];
  int           n0;

  xarb_rr_pkt_if #(.N(N), .DW(DW)) bif ();

  xarb_rr_pkt #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave),
    .grant (grant),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk)
    if (bif.out_valid && bif.out_ready)
      seen.push_back(bif.out_data);

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int k, input logic [DW-1:0] d);
    bif.in_data[k*DW +: DW] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_ovalid"}, 64'(bif.out_valid), 64'h0);
    chk({tag, "_olast"}, 64'(bif.out_last), 64'h0);
    chk({tag, "_odata"}, 64'(bif.out_data), 64'h0);
    chk({tag, "_iready"}, 64'(bif.in_ready), 64'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n         = 1'b0;
    bif.in_valid  = 4'b1111;
    bif.in_last   = 4'b1111;
    bif.out_ready = 1'b1;
    for (int k = 0; k < N; k++) put(k, 32'hA0 + k);

    // reset with every requester asking
    repeat (2) cyc();
    chk_quiet("rst");
    rst_n = 1'b1;
    cyc();

    // continuous single-beat packets from all four
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_grant%0d", i), 64'(grant), 64'(1 << (i % 4)));
      chk($sformatf("rr_busy%0d", i), 64'(busy), 64'h1);
      chk($sformatf("rr_data%0d", i), 64'(bif.out_data),
          64'(32'hA0 + (i % 4)));
      cyc();
      chk($sformatf("rr_gap%0d", i), 64'(grant), 64'h0);
      chk($sformatf("rr_gapv%0d", i), 64'(bif.out_valid), 64'h0);
      if (i < 4) cyc();
    end
    bif.in_valid = '0;
    bif.in_last  = '0;

    // requester 2 alone, three beats
    seen.delete();
    bif.in_valid = 4'b0100;
    put(2, 32'hD0);
    cyc();
    chk("p3_grant", 64'(grant), 64'h4);
    chk("p3_d0", 64'(bif.out_data), 64'hD0);
    chk("p3_ready", 64'(bif.in_ready), 64'h4);
    cyc();
    put(2, 32'hD1);
    #1;
    chk("p3_d1", 64'(bif.out_data), 64'hD1);
    chk("p3_last1", 64'(bif.out_last), 64'h0);
    cyc();
    put(2, 32'hD2);
    bif.in_last[2] = 1'b1;
    #1;
    chk("p3_d2", 64'(bif.out_data), 64'hD2);
    chk("p3_last2", 64'(bif.out_last), 64'h1);
    cyc();
    chk("p3_end_grant", 64'(grant), 64'h0);
    chk("p3_end_busy", 64'(busy), 64'h0);
    bif.in_valid = '0;
    bif.in_last  = '0;
    chk("p3_nbeats", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("p3_seen0", 64'(seen[0]), 64'hD0);
      chk("p3_seen2", 64'(seen[2]), 64'hD2);
    end

    // requester 1 with a 3-cycle stall, 0 and 3 arrive meanwhile
    seen.delete();
    bif.in_valid = 4'b0010;
    put(1, 32'h11);
    cyc();
    chk("st_grant", 64'(grant), 64'h2);
    bif.in_valid = 4'b1011;
    bif.in_last  = 4'b1001;
    put(0, 32'hA0);
    put(3, 32'hA3);
    #1;
    chk("st_d0", 64'(bif.out_data), 64'h11);
    cyc();
    put(1, 32'h12);
    bif.in_last[1] = 1'b1;
    bif.out_ready  = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("st_data%0d", s), 64'(bif.out_data), 64'h12);
      chk($sformatf("st_iready%0d", s), 64'(bif.in_ready), 64'h0);
      chk($sformatf("st_grant%0d", s), 64'(grant), 64'h2);
      cyc();
    end
    bif.out_ready = 1'b1;
    #1;
    chk("st_release", 64'(bif.in_ready), 64'h2);
    cyc();
    chk("st_end", 64'(grant), 64'h0);
    bif.in_valid[1] = 1'b0;
    chk("st_nbeats", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      chk("st_seen0", 64'(seen[0]), 64'h11);
      chk("st_seen1", 64'(seen[1]), 64'h12);
    end
    cyc();
    chk("after1_grant", 64'(grant), 64'h8);
    cyc();
    bif.in_valid[3] = 1'b0;
    chk("after1_gap", 64'(grant), 64'h0);
    cyc();
    chk("after3_grant", 64'(grant), 64'h1);
    cyc();
    bif.in_valid[0] = 1'b0;

    // reset during the second beat of requester 3
    bif.in_valid   = 4'b1000;
    bif.in_last[3] = 1'b0;
    put(3, 32'h31);
    cyc();
    chk("rs_grant", 64'(grant), 64'h8);
    cyc();
    put(3, 32'h32);
    bif.in_valid[0] = 1'b1;
    #1;
    chk("rs_beat2", 64'(bif.out_data), 64'h32);
    n0 = seen.size();
    rst_n = 1'b0;
    #1;
    chk_quiet("rs_mid");
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rs_after_grant", 64'(grant), 64'h1);
    chk("rs_no_xfer", 64'(seen.size()), 64'(n0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
